// File: rtl/a_and_b_stim_chk.sv
// Stimulus/response checker for the registered a_and_b datapath (c = a & b).
// Sweeps every operand pair, compares c two edges after launch and reports errors.
module a_and_b_stim_chk #(
  parameter int unsigned N_VEC = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pi_start,
  output logic [1:0] po_a,
  output logic [2:0] po_b,
  input  logic [3:0] pi_c,
  output logic       po_busy,
  output logic       po_done,
  output logic       po_pass,
  output logic [5:0] po_err_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [5:0] LAST_IDX = 6'(N_VEC);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [1:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic       v1_q, v1_d, v2_q, v2_d;
  logic [3:0] e1_q, e1_d, e2_q, e2_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] err_q, err_d;

  function automatic logic [3:0] exp_of(input logic [4:0] idx);
    return {2'b00, idx[1:0] & idx[3:2]};
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = '0;
    b_d     = '0;
    v1_d    = 1'b0;
    e1_d    = '0;
    v2_d    = v1_q;
    e2_d    = e1_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;

    if (v2_q && (pi_c != e2_q)) err_d = err_q + 6'd1;

    unique case (state_q)
      IDLE: begin
        if (pi_start) begin
          state_d = RUN;
          err_d   = '0;
          pass_d  = 1'b0;
          v1_d    = 1'b1;
          e1_d    = exp_of(5'd0);
          idx_d   = 6'd1;
        end
      end
      RUN: begin
        // idx_q is the next vector to launch; all N_VEC launched once it reaches LAST_IDX
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          a_d   = idx_q[1:0];
          b_d   = idx_q[4:2];
          v1_d  = 1'b1;
          e1_d  = exp_of(idx_q[4:0]);
          idx_d = idx_q + 6'd1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v1_q    <= 1'b0;
      e1_q    <= '0;
      v2_q    <= 1'b0;
      e2_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v1_q    <= v1_d;
      e1_q    <= e1_d;
      v2_q    <= v2_d;
      e2_q    <= e2_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  assign po_a       = a_q;
  assign po_b       = b_q;
  assign po_busy    = (state_q != IDLE);
  assign po_done    = done_q;
  assign po_pass    = pass_q;
  assign po_err_cnt = err_q;

endmodule

// File: tb/tb_a_and_b_stim_chk.sv
// Bench for a_and_b_stim_chk: two instances (32 and 5 vectors) against a datapath
// model with injectable faults, checked each cycle against a run-time-indexed model.
module tb_a_and_b_stim_chk;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start [2];
  logic [1:0] a_o   [2];
  logic [2:0] b_o   [2];
  logic [3:0] c_i   [2];
  logic       busy_o[2];
  logic       done_o[2];
  logic       pass_o[2];
  logic [5:0] err_o [2];
  int         fault = 0;   // 0 good, 1 c[3] stuck 1, 2 c[0] stuck 0

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    a_and_b_stim_chk #(.N_VEC((g == 0) ? 32 : 5)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pi_start  (start[g]),
      .po_a      (a_o[g]),
      .po_b      (b_o[g]),
      .pi_c      (c_i[g]),
      .po_busy   (busy_o[g]),
      .po_done   (done_o[g]),
      .po_pass   (pass_o[g]),
      .po_err_cnt(err_o[g])
    );
  end

  function automatic int nv_of(input int i);
    return (i == 0) ? 32 : 5;
  endfunction

  function automatic int dp(input int a, input int b, input int f);
    int e;
    e = a & (b % 4);
    if (f == 1) return e | 8;
    if (f == 2) return e & 14;
    return e;
  endfunction

  // Vector k carries a = k mod 4, b = k div 4.
  function automatic bit mis(input int k, input int f);
    return dp(k % 4, k / 4, f) != ((k % 4) & ((k / 4) % 4));
  endfunction

  function automatic int err_at(input int nv, input int t, input int f);
    int n = 0;
    for (int k = 0; k < nv; k++)
      if (k + 2 <= t && mis(k, f)) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) c_i[i] <= '0;
      else        c_i[i] <= 4'(dp(int'(a_o[i]), int'(b_o[i]), fault));
    end
  end

  // Model: t = edges since E0 of the current run.
  bit act [2];
  int t   [2];
  int errm[2];
  bit passm[2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act[i] = 0; t[i] = 0; errm[i] = 0; passm[i] = 0;
      end else begin
        if (act[i]) begin
          if (t[i] == nv_of(i) + 1) act[i] = 0;
          else t[i]++;
        end
        if (!act[i] && start[i]) begin
          act[i] = 1; t[i] = 0;
        end
        if (act[i]) begin
          errm[i] = err_at(nv_of(i), t[i], fault);
          if (t[i] == 0) passm[i] = 0;
          if (t[i] == nv_of(i) + 1) passm[i] = (errm[i] == 0);
        end
      end
    end
  end

  task automatic chk(input string nm, input int i, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_mis++;
      $display("FAIL %s inst%0d @%0t got=%0d want=%0d", nm, i, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int nv, ea, eb;
      nv = nv_of(i);
      ea = (act[i] && t[i] < nv) ? t[i] % 4 : 0;
      eb = (act[i] && t[i] < nv) ? (t[i] / 4) % 8 : 0;
      chk("po_a", i, int'(a_o[i]), ea);
      chk("po_b", i, int'(b_o[i]), eb);
      chk("po_busy", i, int'(busy_o[i]), int'(act[i] && t[i] <= nv));
      chk("po_done", i, int'(done_o[i]), int'(act[i] && t[i] == nv + 1));
      chk("po_err_cnt", i, int'(err_o[i]), errm[i]);
      chk("po_pass", i, int'(pass_o[i]), int'(passm[i]));
    end
  end

  task automatic chk_zero(input int i);
    chk("rst_a", i, int'(a_o[i]), 0);
    chk("rst_b", i, int'(b_o[i]), 0);
    chk("rst_busy", i, int'(busy_o[i]), 0);
    chk("rst_done", i, int'(done_o[i]), 0);
    chk("rst_pass", i, int'(pass_o[i]), 0);
    chk("rst_err", i, int'(err_o[i]), 0);
  endtask

  // Starts a run on instance i at the next edge, optionally poking start during
  // RUN and DRAIN, and checks latency and final results against literals.
  task automatic run(input int i, input int lat, input int err, input bit pass, input bit poke);
    int cnt = 0;
    int nd = 0;
    bit seen = 0;
    start[i] = 1'b1;
    while (cnt < 100 && !seen) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 1) begin
        chk("e0_err_clr", i, int'(err_o[i]), 0);
        chk("e0_pass_clr", i, int'(pass_o[i]), 0);
      end
      start[i] = poke && ((cnt - 1) == 10 || (cnt - 1) == nv_of(i));
      if (done_o[i]) seen = 1;
    end
    start[i] = 1'b0;
    if (!seen) chk("done_timeout", i, 0, 1);
    chk("latency", i, cnt - 1, lat);
    chk("final_err", i, int'(err_o[i]), err);
    chk("final_pass", i, int'(pass_o[i]), int'(pass));
    repeat (8) begin
      @(negedge clk);
      if (done_o[i]) nd++;
    end
    chk("extra_done", i, nd, 0);
  endtask

  initial begin
    int nd;
    start[0] = 1'b0;
    start[1] = 1'b0;
    #23;
    for (int i = 0; i < 2; i++) chk_zero(i);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) chk_zero(i);

    run(0, 33, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle must clear outputs without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    fault = 1;
    run(0, 33, 32, 1'b0, 1'b1);
    fault = 2;
    run(0, 33, 8, 1'b0, 1'b0);

    fault = 0;
    run(1, 6, 0, 1'b1, 1'b0);
    fault = 1;
    run(1, 6, 5, 1'b0, 1'b1);
    fault = 2;
    run(1, 6, 0, 1'b1, 1'b0);

    // Reset while vector 10 is driven, then a clean full rerun.
    fault = 1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_a", 0, int'(a_o[0]), 2);
    chk("mid_b", 0, int'(b_o[0]), 2);
    #2 rst_n = 1'b0;
    #1 chk_zero(0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o[0]) nd++;
    end
    chk("abort_done", 0, nd, 0);
    fault = 0;
    run(0, 33, 0, 1'b1, 1'b0);

    // Held start: back-to-back runs, done every N_VEC+2 edges.
    start[1] = 1'b1;
    nd = 0;
    repeat (21) begin
      @(posedge clk);
      @(negedge clk);
      if (done_o[1]) nd++;
    end
    start[1] = 1'b0;
    chk("held_start_dones", 1, nd, 3);
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
